// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FIR width constants and the round/saturate helper
// Purpose: default sample widths for the FIR chain, and the quantizer used on
//          decimated sums. Shared with the fir_4tap benches.
// Ports:   none (package)
// Config:  FIR_DECIM_SAT_EN is not read here; callers pass the saturation
//          enable so one helper serves both builds.
package fir_pkg;

  localparam int FIR_IN_W  = 16;
  localparam int FIR_OUT_W = 8;

  // Round half up, arithmetic shift, then optionally clamp to a signed out_w
  // range. Evaluated at 32 bits, so the accumulator plus rounding bias must
  // fit in 31 bits. Callers keep the low out_w bits; with sat=0 that is the
  // two's complement wrap.
  function automatic logic signed [31:0] round_sat(input logic signed [31:0] sum,
                                                   input int shift,
                                                   input int out_w,
                                                   input bit sat);
    logic signed [31:0] r;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    r  = (sum + (32'sd1 <<< (shift - 1))) >>> shift;
    hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (out_w - 1));
    if (sat) begin
      if (r > hi) r = hi;
      else if (r < lo) r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// rtl/fir_out_fifo.sv - synchronous first-word-fall-through output FIFO
// Purpose: buffers quantized results between the decimator and a stalling
//          consumer. The head word is visible on o_data while not empty.
// Ports:   Clk, Rst (sync, active high)
//          i_push/i_data  write request; ignored when full unless popping
//          i_pop          read request; ignored when empty
//          o_data         head word, 0 when empty
//          o_full, o_empty, o_count (0..DEPTH)
module fir_out_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       i_push,
  input  logic [W-1:0]               i_data,
  input  logic                       i_pop,
  output logic [W-1:0]               o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [PW:0]   r_cnt;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_cnt == (PW+1)'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign o_count   = r_cnt;
  assign o_data    = o_empty ? '0 : r_mem[r_rd];
  assign w_do_pop  = i_pop & ~o_empty;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge Clk) begin
    if (w_do_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/fir_decim_quant.sv
// rtl/fir_decim_quant.sv - integrate-and-dump decimator with round/saturate and output FIFO
// Purpose: sums DECIM enabled input samples, quantizes the sum to OUT_W bits
//          and queues the result for a valid/ready consumer.
// Ports:   Clk, Rst (sync, active high)
//          In_en, Din           input sample stream (Din signed IN_W)
//          Dout, Dout_valid     FIFO head, Dout is 0 while not valid
//          Dout_ready           consumer accepts the head this cycle
//          Ovf                  sticky, a result was dropped on a full FIFO
// Config:  FIR_DECIM_SAT_EN defined -> saturate; undefined -> wrap to OUT_W.
module fir_decim_quant import fir_pkg::*; #(
  parameter int IN_W       = FIR_IN_W,
  parameter int OUT_W      = FIR_OUT_W,
  parameter int DECIM      = 4,
  parameter int SHIFT      = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    In_en,
  input  logic signed [IN_W-1:0]  Din,
  output logic signed [OUT_W-1:0] Dout,
  output logic                    Dout_valid,
  input  logic                    Dout_ready,
  output logic                    Ovf
);

  localparam int CW = $clog2(DECIM);
  localparam int AW = IN_W + CW;
`ifdef FIR_DECIM_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic signed [AW-1:0]  r_acc;
  logic [CW-1:0]         r_cnt;
  logic [OUT_W-1:0]      r_q;
  logic                  r_qv;
  logic                  r_ovf;

  logic signed [AW-1:0]  w_din_ext;
  logic signed [AW-1:0]  w_sum;
  logic [OUT_W-1:0]      w_q;
  logic                  w_dump;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [OUT_W-1:0]      w_fifo_data;
  logic [$clog2(FIFO_DEPTH):0] w_fifo_count;

  assign w_din_ext = $signed({{(AW-IN_W){Din[IN_W-1]}}, Din});
  assign w_sum     = r_acc + w_din_ext;
  assign w_dump    = In_en && (r_cnt == CW'(DECIM - 1));
  // Keeping the low OUT_W bits is the wrap behaviour when saturation is off.
  assign w_q       = OUT_W'(round_sat(32'(w_sum), SHIFT, OUT_W, SAT_EN));
  assign w_pop     = Dout_ready & ~w_empty;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_q   <= '0;
      r_qv  <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      if (In_en) begin
        if (w_dump) begin
          r_acc <= '0;
          r_cnt <= '0;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + 1'b1;
        end
      end
      // The held result is consumed (written or dropped) every edge it is valid.
      if (w_dump) r_q <= w_q;
      r_qv <= w_dump;
      if (r_qv && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  fir_out_fifo #(
    .W     (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clk     (Clk),
    .Rst     (Rst),
    .i_push  (r_qv),
    .i_data  (r_q),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_fifo_count)
  );

  assign Dout       = $signed(w_fifo_data);
  assign Dout_valid = ~w_empty;
  assign Ovf        = r_ovf;

endmodule

// File: tb/tb_fir_decim_quant.sv
// tb/tb_fir_decim_quant.sv - self-checking bench for fir_decim_quant
module tb_fir_decim_quant;

  localparam int DECIM = 4;
  localparam int DEPTH = 4;

  logic              Clk = 1'b0;
  logic              Rst = 1'b1;
  logic              In_en = 1'b0;
  logic signed [15:0] Din = '0;
  logic signed [7:0] Dout;
  logic              Dout_valid;
  logic              Dout_ready = 1'b0;
  logic              Ovf;

  int checks = 0;
  int failures = 0;

  // Reference model state: pending frame samples, pending result, queued words.
  int frame[$];
  int fq[$];
  bit pend_v = 0;
  int pend_d = 0;
  bit m_ovf = 0;

  logic       e_v;
  logic [7:0] e_d;
  logic       e_o;

  fir_decim_quant dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .In_en      (In_en),
    .Din        (Din),
    .Dout       (Dout),
    .Dout_valid (Dout_valid),
    .Dout_ready (Dout_ready),
    .Ovf        (Ovf)
  );

  always #5 Clk = ~Clk;

  function automatic int quant(input int sum);
    int x;
    int r;
    x = sum + 512;
    r = (x >= 0) ? x / 1024 : -((-x + 1023) / 1024);
`ifdef FIR_DECIM_SAT_EN
    if (r > 127) r = 127;
    if (r < -128) r = -128;
`else
    r = ((r + 128) % 256 + 256) % 256 - 128;
`endif
    return r;
  endfunction

  // Advance one clock: the model consumes the inputs present before the edge,
  // outputs are sampled on the falling edge.
  task automatic tick();
    bit en;
    bit rst;
    bit rdy;
    bit pop;
    int d;
    int s;
    en = In_en; rst = Rst; rdy = Dout_ready; d = Din;
    @(posedge Clk);
    if (rst) begin
      frame.delete(); fq.delete(); pend_v = 0; m_ovf = 0;
    end else begin
      pop = (fq.size() > 0) && rdy;
      if (pop) void'(fq.pop_front());
      if (pend_v) begin
        if (fq.size() < DEPTH) fq.push_back(pend_d);
        else m_ovf = 1;
      end
      pend_v = 0;
      if (en) begin
        frame.push_back(d);
        if (frame.size() == DECIM) begin
          s = 0;
          foreach (frame[i]) s += frame[i];
          pend_d = quant(s);
          pend_v = 1;
          frame.delete();
        end
      end
    end
    @(negedge Clk);
    e_v = (fq.size() > 0);
    e_d = e_v ? 8'(fq[0]) : 8'd0;
    e_o = m_ovf;
  endtask

  task automatic test_reset();
    Rst = 1; In_en = 1; Din = 16'sd1000; Dout_ready = 1;
    tick(); tick();
    checks++; if (Dout_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", Dout_valid); end
    checks++; if (Dout !== 8'sd0) begin failures++; $display("FAIL reset_dout got=%0d exp=0", Dout); end
    checks++; if (Ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", Ovf); end
    Rst = 0; In_en = 0;
  endtask

  task automatic test_basic();
    Din = 16'sd1000; In_en = 1; Dout_ready = 1;
    for (int i = 0; i < DECIM; i++) begin
      tick();
      checks++;
      if ({Dout_valid, Dout, Ovf} !== {e_v, e_d, e_o}) begin
        failures++; $display("FAIL basic_cycle%0d got v=%b d=%0d o=%b exp v=%b d=%0d o=%b", i, Dout_valid, Dout, Ovf, e_v, $signed(e_d), e_o);
      end
    end
    checks++; if (Dout_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", Dout_valid); end
    In_en = 0;
    tick();
    checks++; if (Dout_valid !== 1'b1 || Dout !== 8'sd4) begin failures++; $display("FAIL basic_latency got v=%b d=%0d exp v=1 d=4", Dout_valid, Dout); end
    tick();
    checks++; if (Dout_valid !== 1'b0 || Dout !== 8'sd0) begin failures++; $display("FAIL basic_pulse got v=%b d=%0d exp v=0 d=0", Dout_valid, Dout); end
  endtask

  task automatic test_extremes();
    logic signed [15:0] vals[2];
    logic signed [7:0]  exps[2];
    vals[0] = 16'sh7fff; vals[1] = -16'sh8000;
`ifdef FIR_DECIM_SAT_EN
    exps[0] = 8'sd127;
`else
    exps[0] = -8'sd128;
`endif
    exps[1] = -8'sd128;
    Dout_ready = 1;
    for (int k = 0; k < 2; k++) begin
      Din = vals[k]; In_en = 1;
      for (int i = 0; i < DECIM; i++) begin
        tick();
        checks++;
        if ({Dout_valid, Dout, Ovf} !== {e_v, e_d, e_o}) begin
          failures++; $display("FAIL extreme%0d_cycle%0d got v=%b d=%0d exp v=%b d=%0d", k, i, Dout_valid, Dout, e_v, $signed(e_d));
        end
      end
      In_en = 0;
      tick();
      checks++; if (Dout_valid !== 1'b1 || Dout !== exps[k]) begin failures++; $display("FAIL extreme%0d_result got v=%b d=%0d exp v=1 d=%0d", k, Dout_valid, Dout, exps[k]); end
      tick();
    end
  endtask

  task automatic test_overflow();
    Rst = 1; tick(); Rst = 0;
    Dout_ready = 0; Din = 16'sd1000; In_en = 1;
    for (int i = 0; i < 5 * DECIM; i++) begin
      tick();
      checks++;
      if ({Dout_valid, Dout, Ovf} !== {e_v, e_d, e_o}) begin
        failures++; $display("FAIL ovf_fill_cycle%0d got v=%b d=%0d o=%b exp v=%b d=%0d o=%b", i, Dout_valid, Dout, Ovf, e_v, $signed(e_d), e_o);
      end
    end
    In_en = 0;
    tick();
    checks++; if (Ovf !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", Ovf); end
    Dout_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (Dout_valid !== 1'b1 || Dout !== 8'sd4) begin failures++; $display("FAIL ovf_drain%0d got v=%b d=%0d exp v=1 d=4", i, Dout_valid, Dout); end
      tick();
    end
    checks++; if (Dout_valid !== 1'b0) begin failures++; $display("FAIL ovf_drained got=%b exp=0", Dout_valid); end
    checks++; if (Ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", Ovf); end
  endtask

  task automatic test_full_read();
    Rst = 1; tick(); Rst = 0;
    Dout_ready = 0; Din = 16'sd1000; In_en = 1;
    for (int i = 0; i < 5 * DECIM; i++) tick();
    // Fifth result is pending now; the FIFO is full. Read on the write edge.
    In_en = 0; Dout_ready = 1;
    tick();
    Dout_ready = 0;
    checks++; if (Ovf !== 1'b0) begin failures++; $display("FAIL fullrd_ovf got=%b exp=0", Ovf); end
    checks++; if (dut.w_fifo_count !== 3'd4) begin failures++; $display("FAIL fullrd_count got=%0d exp=4", dut.w_fifo_count); end
    checks++;
    if ({Dout_valid, Dout, Ovf} !== {e_v, e_d, e_o}) begin
      failures++; $display("FAIL fullrd_model got v=%b d=%0d o=%b exp v=%b d=%0d o=%b", Dout_valid, Dout, Ovf, e_v, $signed(e_d), e_o);
    end
    Dout_ready = 1;
    for (int i = 0; i < DEPTH + 1; i++) tick();
  endtask

  task automatic test_reset_midframe();
    Rst = 1; tick(); Rst = 0;
    Dout_ready = 1; Din = 16'sd1000; In_en = 1;
    tick(); tick();
    Rst = 1; tick(); Rst = 0;
    for (int i = 0; i < DECIM; i++) begin
      tick();
      checks++;
      if ({Dout_valid, Dout, Ovf} !== {e_v, e_d, e_o}) begin
        failures++; $display("FAIL midrst_cycle%0d got v=%b d=%0d exp v=%b d=%0d", i, Dout_valid, Dout, e_v, $signed(e_d));
      end
    end
    In_en = 0;
    tick();
    checks++; if (Dout_valid !== 1'b1 || Dout !== 8'sd4 || Ovf !== 1'b0) begin failures++; $display("FAIL midrst_result got v=%b d=%0d o=%b exp v=1 d=4 o=0", Dout_valid, Dout, Ovf); end
    tick();
  endtask

  task automatic test_enable_alternate();
    int n;
    n = 0;
    Rst = 1; tick(); Rst = 0;
    Dout_ready = 1;
    for (int i = 0; i < 8 * DECIM; i++) begin
      In_en = (i % 2 == 0);
      Din = In_en ? 16'sd1000 : 16'($urandom);
      tick();
      checks++;
      if ({Dout_valid, Dout, Ovf} !== {e_v, e_d, e_o}) begin
        failures++; $display("FAIL alt_cycle%0d got v=%b d=%0d exp v=%b d=%0d", i, Dout_valid, Dout, e_v, $signed(e_d));
      end
      if (Dout_valid === 1'b1 && Dout === 8'sd4) n++;
    end
    In_en = 0;
    checks++; if (n !== 4) begin failures++; $display("FAIL alt_results got=%0d exp=4", n); end
  endtask

  task automatic test_random();
    Rst = 1; tick(); Rst = 0;
    for (int i = 0; i < 800; i++) begin
      Rst = ($urandom_range(0, 149) == 0);
      In_en = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0: Din = 16'sh7fff;
        1: Din = -16'sh8000;
        default: Din = 16'($urandom);
      endcase
      Dout_ready = (i % 200 < 60) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0);
      tick();
      checks++;
      if ({Dout_valid, Dout, Ovf} !== {e_v, e_d, e_o}) begin
        failures++; $display("FAIL rand_cycle%0d got v=%b d=%0d o=%b exp v=%b d=%0d o=%b", i, Dout_valid, Dout, Ovf, e_v, $signed(e_d), e_o);
      end
    end
    Rst = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_overflow();
    test_full_read();
    test_reset_midframe();
    test_enable_alternate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_decim_quant.md
# fir_decim_quant

Downstream stage for the 4-tap FIR: consumes the filter's signed 16-bit output stream, integrate-and-dump decimates it by DECIM, then rounds and saturates each result to OUT_W bits. Results are buffered in a small FIFO and delivered over a valid/ready interface to the next DSP stage or a capture block. This lets the FIR run at full sample rate while downstream logic runs at a lower rate and can stall.

## Interface
- IN_W, 16, input sample width (matches FIR Yout)
- OUT_W, 8, output sample width
- DECIM, 4, decimation factor; power of two, 2..16
- SHIFT, 10, right-shift applied to the accumulated sum; 1 ≤ SHIFT < IN_W+log2(DECIM)
- FIFO_DEPTH, 4, output buffer entries; power of two ≥ 2
- Clk  in  1  single clock, rising edge
- Rst  in  1  synchronous, active-high reset
- In_en  in  1  Din valid this cycle; tie high when fed directly by fir_4tap
- Din  in  IN_W  signed input sample
- Dout  out  OUT_W  signed output sample; 0 whenever Dout_valid=0
- Dout_valid  out  1  FIFO head valid
- Dout_ready  in  1  consumer accepts Dout this cycle
- Ovf  out  1  sticky: a result was dropped because the FIFO was full

## Operation
- Accumulator acc, width IN_W+log2(DECIM), signed; phase counter cnt, 0..DECIM-1.
- Edge with In_en=1 and cnt<DECIM-1: acc += Din, cnt++.
- Edge with In_en=1 and cnt==DECIM-1 (dump): sum = acc+Din is quantized into q_reg, q_vld←1; acc←0, cnt←0.
- In_en=0: acc and cnt hold; the sample is ignored.
- Quantize: r = (sum + 2^(SHIFT-1)) >>> SHIFT (round half up, arithmetic shift), then saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Edge with q_vld=1: q_reg is written into the FIFO unless the FIFO is full and not being read this edge. A dropped word sets Ovf; Ovf clears only on Rst. q_vld clears unless a new dump occurs on the same edge.
- FIFO is first-word-fall-through. Transfer occurs when Dout_valid & Dout_ready. Simultaneous read and write while full: both happen, no drop. Write while empty: no bypass.
- Pointers wrap modulo FIFO_DEPTH. Occupancy counter ranges 0..FIFO_DEPTH.

## Timing
- Rst: acc=0, cnt=0, q_vld=0, FIFO empty, Dout=0, Dout_valid=0, Ovf=0. Reset mid-frame discards the partial sum; the next enabled sample starts phase 0.
- Latency: the final sample of a frame sampled at edge k gives Dout_valid=1 after edge k+1 (FIFO empty, and no reset in between).
- Throughput: at most one result per DECIM enabled samples. With Dout_ready held high, the FIFO never exceeds 1 entry.
- Dout_valid and Dout are stable while Dout_ready=0.

## Configuration
- FIR_DECIM_SAT_EN defined: saturation as described above.
- FIR_DECIM_SAT_EN undefined: the saturation logic is removed; r wraps, keeping the low OUT_W bits (two's complement). Rounding is unchanged.

## Structure
- Package fir_pkg holds the default width constants (FIR_IN_W=16, FIR_OUT_W=8) and a sat/round helper function. It is shared with fir_4tap benches.
- One sub-module, fir_out_fifo: parameterised sync FWFT FIFO with push, pop, full, empty and count.
- Accumulator, phase counter and quantizer live in the top module.

## Test plan
Defaults apply with FIR_DECIM_SAT_EN defined unless stated.
- Din=1000 ×4, In_en=1, Dout_ready=1 -> sum 4000, one word Dout=4, Dout_valid pulse 1 cycle, 2 edges after the 4th sample.
- Din=32767 ×4 -> Dout=127. Din=-32768 ×4 -> Dout=-128. Same stimulus with macro undefined -> 32767 case gives -128 (wrap).
- Dout_ready=0, Din=1000 for 5 frames -> 4 words buffered, 5th dropped, Ovf=1. Then Dout_ready=1 -> four words of 4 on consecutive cycles, then Dout_valid=0, Ovf stays 1.
- FIFO full, Dout_ready=1 on the same edge as a q_reg write -> no drop, Ovf stays 0, occupancy stays 4.
- Rst pulse after 2 of 4 samples, then Din=1000 ×4 -> Dout=4 (no residue), Ovf=0.
- In_en alternating 1/0 with Din=1000 on enabled cycles, 0 otherwise -> one result of 4 per 8 clocks; disabled samples not counted.
